// File: rtl/sa_pkg.sv
// Shared definitions for the weight-stationary systolic array blocks:
// default geometry, feeder FSM encoding and lane packing helper.
package sa_pkg;

    localparam int SA_DATA_WIDTH = 8;
    localparam int SA_ROWS       = 4;
    localparam int SA_COLS       = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } feeder_state_t;

    // Lane r of a packed vector occupies bits [r*width +: width].
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth registered shift register with synchronous clear; one per
// array row, depth chosen to produce the diagonal skew.
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Activation skew feeder: accepts one vector per cycle, skews lane r by r
// cycles, appends a zero drain per tile and signals tile completion.
module systolic_feeder
    import sa_pkg::*;
#(
    parameter int DATA_WIDTH = SA_DATA_WIDTH,
    parameter int ROWS       = SA_ROWS,
    parameter int COLS       = SA_COLS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [ROWS*DATA_WIDTH-1:0] in_data_i,
    input  logic                       in_last_i,
    output logic [ROWS*DATA_WIDTH-1:0] data_a_o,
    output logic [ROWS-1:0]            row_valid_o,
    output logic                       acc_en_o,
    output logic                       busy_o,
    output logic                       tile_done_o
);

    localparam int FLUSH_CYCLES = ROWS - 1 + COLS;
    localparam int CNT_W        = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    feeder_state_t    state, state_n;
    logic [CNT_W-1:0] flush_cnt, flush_cnt_n;
    logic             ready;
    logic             done_n;
    logic             hs;
    logic             acc_en_p1;
    logic             tile_done_p1;

    assign in_ready_o = ready && !rst;
    assign hs         = in_valid_i && in_ready_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            flush_cnt    <= '0;
            acc_en_p1    <= 1'b0;
            tile_done_p1 <= 1'b0;
        end else begin
            state        <= state_n;
            flush_cnt    <= flush_cnt_n;
            acc_en_p1    <= (state_n != IDLE);
            tile_done_p1 <= done_n;
        end
    end

    always_comb begin
        state_n     = state;
        flush_cnt_n = flush_cnt;
        ready       = 1'b0;
        done_n      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (in_valid_i) begin
                    if (in_last_i) begin
                        state_n     = FLUSH;
                        flush_cnt_n = FLUSH_LOAD;
                    end else begin
                        state_n = STREAM;
                    end
                end
            end
            STREAM: begin
                ready = 1'b1;
                if (in_valid_i && in_last_i) begin
                    state_n     = FLUSH;
                    flush_cnt_n = FLUSH_LOAD;
                end
            end
            FLUSH: begin
                if (flush_cnt == '0) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    flush_cnt_n = flush_cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign acc_en_o    = acc_en_p1;
    assign tile_done_o = tile_done_p1;
    assign busy_o      = (state != IDLE);

    // Skew stage: lane r sees only handshaken data; bubbles and drain are zero.
    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        localparam int LSB = lane_lsb(r, DATA_WIDTH);
        logic signed [DATA_WIDTH-1:0] lane_in;
        logic        [DATA_WIDTH:0]   lane_out;

        assign lane_in = hs ? in_data_i[LSB +: DATA_WIDTH] : '0;

        skew_delay_line #(
            .DEPTH (r + 1),
            .WIDTH (DATA_WIDTH + 1)
        ) u_delay (
            .clk  (clk),
            .clr  (rst),
            .din  ({lane_in, hs}),
            .dout (lane_out)
        );

        assign data_a_o[LSB +: DATA_WIDTH] = lane_out[DATA_WIDTH:1];
        assign row_valid_o[r]              = lane_out[0];
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder with hand-specified lane vectors and
// cycle-indexed output logging.
module tb_systolic_feeder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic [31:0] data_a;
    logic [3:0]  row_valid;
    logic        acc_en;
    logic        busy;
    logic        tile_done;

    systolic_feeder #(.DATA_WIDTH(8), .ROWS(4), .COLS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_last_i   (in_last),
        .data_a_o    (data_a),
        .row_valid_o (row_valid),
        .acc_en_o    (acc_en),
        .busy_o      (busy),
        .tile_done_o (tile_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] log_data  [0:1023];
    logic [3:0]  log_rv    [0:1023];
    logic        log_acc   [0:1023];
    logic        log_done  [0:1023];
    logic        log_ready [0:1023];
    logic        log_hs    [0:1023];

    always @(negedge clk) begin
        if (cyc < 1024) begin
            log_data[cyc]  <= data_a;
            log_rv[cyc]    <= row_valid;
            log_acc[cyc]   <= acc_en;
            log_done[cyc]  <= tile_done;
            log_ready[cyc] <= in_ready;
            log_hs[cyc]    <= in_valid && in_ready;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Vector entering lane 0 at cycle t0+k (zero and invalid for bubbles/drain).
    logic [31:0] ev_dat [0:15];
    logic        ev_vld [0:15];

    task automatic chk_skew(input string tag, input int t0, input int n_in, input int win);
        for (int c = t0; c < t0 + win; c++) begin
            logic [31:0] e_d;
            logic [3:0]  e_v;
            e_d = '0;
            e_v = '0;
            for (int r = 0; r < 4; r++) begin
                int k;
                k = c - t0 - 1 - r;
                if (k >= 0 && k < n_in) begin
                    e_d[r*8 +: 8] = ev_dat[k][r*8 +: 8];
                    e_v[r]        = ev_vld[k];
                end
            end
            chk($sformatf("%s_data@t+%0d", tag, c - t0), log_data[c], e_d);
            chk($sformatf("%s_rv@t+%0d", tag, c - t0), {28'd0, log_rv[c]}, {28'd0, e_v});
        end
    endtask

    function automatic int count_done(input int from, input int to);
        int n;
        n = 0;
        for (int c = from; c <= to; c++) if (log_done[c] === 1'b1) n++;
        return n;
    endfunction

    task automatic drive(input logic v, input logic [31:0] d, input logic l);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, $urandom, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    int t0;
    int t_acc;
    int lows;
    logic accepted;

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, in_ready}, 0);
        chk("rst_data", data_a, 0);
        chk("rst_rv", {28'd0, row_valid}, 0);
        chk("rst_ctrl", {29'd0, acc_en, busy, tile_done}, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", {31'd0, in_ready}, 1);
        @(posedge clk);
        #1;
        idle(2);

        // Single-vector tile {1,2,3,4}
        t0 = cyc;
        drive(1'b1, 32'h04030201, 1'b1);
        idle(12);
        ev_dat[0] = 32'h04030201; ev_vld[0] = 1'b1;
        chk_skew("single", t0, 1, 11);
        chk("single_done_cnt", count_done(t0, t0 + 11), 1);
        chk("single_done_at8", {31'd0, log_done[t0+8]}, 1);
        chk("single_acc_t0", {31'd0, log_acc[t0]}, 0);
        chk("single_acc_t1", {31'd0, log_acc[t0+1]}, 1);
        chk("single_acc_t8", {31'd0, log_acc[t0+8]}, 0);

        // Four back-to-back vectors
        t0 = cyc;
        for (int k = 1; k <= 4; k++) drive(1'b1, {4{8'(k)}}, k == 4);
        idle(14);
        for (int k = 0; k < 4; k++) begin
            ev_dat[k] = {4{8'(k + 1)}}; ev_vld[k] = 1'b1;
        end
        chk_skew("b2b", t0, 4, 12);
        lows = 0;
        for (int c = t0 + 1; c <= t0 + 10; c++) if (log_acc[c] !== 1'b1) lows++;
        chk("b2b_acc_gaps", lows, 0);
        chk("b2b_done_at11", {31'd0, log_done[t0+11]}, 1);
        chk("b2b_done_cnt", count_done(t0, t0 + 13), 1);
        chk("b2b_acc_after", {31'd0, log_acc[t0+11]}, 0);

        // Bubble between vectors 5 and 6
        t0 = cyc;
        drive(1'b1, 32'h05050505, 1'b0);
        idle(1);
        drive(1'b1, 32'h06060606, 1'b1);
        idle(14);
        ev_dat[0] = 32'h05050505; ev_vld[0] = 1'b1;
        ev_dat[1] = 32'h0;        ev_vld[1] = 1'b0;
        ev_dat[2] = 32'h06060606; ev_vld[2] = 1'b1;
        chk_skew("bubble", t0, 3, 11);
        chk("bubble_done_at10", {31'd0, log_done[t0+10]}, 1);

        // Backpressure during FLUSH
        t0 = cyc;
        drive(1'b1, 32'h09090909, 1'b1);
        in_valid = 1'b1;
        in_data  = 32'h07070707;
        in_last  = 1'b1;
        accepted = 1'b0;
        t_acc    = -1;
        for (int i = 0; i < 20 && !accepted; i++) begin
            accepted = in_ready;
            t_acc    = cyc;
            @(posedge clk);
            #1;
        end
        if (!accepted) chk("bp_timeout", 0, 1);
        idle(14);
        lows = 0;
        for (int c = t0 + 1; c <= t0 + 8; c++) if (log_ready[c] === 1'b0) lows++;
        chk("bp_ready_low_cycles", lows, 7);
        chk("bp_accept_cycle", t_acc - t0, 8);
        chk("bp_hs_on_done", {30'd0, log_hs[t0+8], log_done[t0+8]}, 2'b11);
        ev_dat[0] = 32'h09090909; ev_vld[0] = 1'b1;
        for (int k = 1; k < 8; k++) begin
            ev_dat[k] = 32'h0; ev_vld[k] = 1'b0;
        end
        ev_dat[8] = 32'h07070707; ev_vld[8] = 1'b1;
        chk_skew("bp", t0, 9, 14);
        chk("bp_done_cnt", count_done(t0, t0 + 18), 2);
        chk("bp_done2_at16", {31'd0, log_done[t0+16]}, 1);

        // Signed extremes {-128,127,-1,0}
        t0 = cyc;
        drive(1'b1, 32'h00FF7F80, 1'b1);
        idle(12);
        ev_dat[0] = 32'h00FF7F80; ev_vld[0] = 1'b1;
        chk_skew("signed", t0, 1, 10);

        // Reset two cycles after first handshake
        t0 = cyc;
        drive(1'b1, 32'h11111111, 1'b0);
        drive(1'b1, 32'h22222222, 1'b0);
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("mid_ready_in_rst", {31'd0, in_ready}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_ready_after", {31'd0, in_ready}, 1);
        @(posedge clk);
        #1;
        idle(14);
        chk("mid_pre_lane0", {24'd0, log_data[t0+2][7:0]}, 32'h22);
        chk("mid_pre_acc", {31'd0, log_acc[t0+2]}, 1);
        chk("mid_data_cleared", log_data[t0+3], 0);
        chk("mid_rv_cleared", {28'd0, log_rv[t0+3]}, 0);
        chk("mid_acc_cleared", {31'd0, log_acc[t0+3]}, 0);
        chk("mid_no_done", count_done(t0, t0 + 16), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Input skew feeder for the weight-stationary systolic array. It accepts one activation vector per cycle over a valid/ready stream and drives the array's per-row activation inputs with the diagonal skew the array requires: row r is delayed r cycles relative to row 0. After each tile it appends a zero-fill drain so that partial sums fully exit the array. It generates the array's accumulator enable and a tile-done pulse for the downstream result collector.

## Interface
Parameters:
- DATA_WIDTH, 8, signed activation width
- ROWS, 4, array rows; one activation lane per row
- COLS, 4, array columns; sets the drain length
- FLUSH_CYCLES, derived localparam = ROWS-1+COLS (7 by default), number of zero-fill drain cycles

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid_i  in  1  input vector valid
- in_ready_o  out  1  feeder can accept a vector
- in_data_i  in  ROWS*DATA_WIDTH  lane r = bits [r*DATA_WIDTH +: DATA_WIDTH], signed
- in_last_i  in  1  marks the final vector of a tile; sampled only on handshake
- data_a_o  out  ROWS*DATA_WIDTH  skewed lanes to array row inputs, same packing as in_data_i
- row_valid_o  out  ROWS  bit r high when lane r carries accepted data (not fill)
- acc_en_o  out  1  array accumulator enable
- busy_o  out  1  high in STREAM or FLUSH
- tile_done_o  out  1  one-cycle pulse at end of drain

## Operation
- A handshake occurs when in_valid_i and in_ready_o are both high.
- FSM states:
  - IDLE: in_ready_o=1, acc_en_o=0.
    - Handshake with in_last_i=0 → STREAM.
    - Handshake with in_last_i=1 → FLUSH (single-vector tile).
  - STREAM: in_ready_o=1, acc_en_o=1.
    - Handshake with in_last_i=1 → FLUSH.
    - Cycle with no handshake: a bubble (all-zero vector, row_valid bit 0) enters lane 0 of the skew. Zero products leave accumulation unaffected, so the array tolerates bubbles.
  - FLUSH: in_ready_o=0, acc_en_o=1. Zeros enter the skew for FLUSH_CYCLES cycles, counted by flush_cnt from FLUSH_CYCLES-1 down to 0. At 0 → IDLE, and tile_done_o is pulsed in the first IDLE cycle.
- Skew: each lane r is a registered delay line of depth r+1. Each entry carries {data, valid}. Every entry advances every cycle; there is no stall path.
- Data passes unmodified; there is no arithmetic on the data path. flush_cnt is $clog2(FLUSH_CYCLES+1) bits wide.
- in_data_i lanes are ignored when no handshake occurs.

## Timing
- Lane r latency: a vector accepted in cycle t appears on lane r of data_a_o in cycle t+1+r, with row_valid_o[r]=1 in that cycle.
- Maximum throughput is one vector per cycle.
- acc_en_o is registered; it rises in the cycle after the first handshake of a tile.
- Tile timeline: the last vector is accepted at cycle t_L. The last valid data reaches lane ROWS-1 at t_L+ROWS. tile_done_o is high at cycle t_L+FLUSH_CYCLES+1.
- Reset values:
  - state=IDLE, all delay lines cleared.
  - data_a_o=0, row_valid_o=0, acc_en_o=0, busy_o=0, tile_done_o=0.
  - in_ready_o=0 while rst is high; 1 in the first cycle after rst deasserts.
- Reset mid-tile aborts the tile immediately: delay lines are zeroed, no tile_done_o pulse is produced, and the in-flight vectors are lost.
- Back-to-back tiles: a new tile may start in the IDLE cycle that carries tile_done_o.
- in_valid_i during FLUSH is held off by in_ready_o=0; the source must hold its data stable.

## Structure
- Shared package sa_pkg holds:
  - the default parameters DATA_WIDTH, ROWS, COLS;
  - the FSM enum feeder_state_t {IDLE, STREAM, FLUSH};
  - the lane-pack helper function.
- Sub-module skew_delay_line(DEPTH, WIDTH) is a registered shift register with synchronous clear, instantiated once per lane with DEPTH=r+1 and WIDTH=DATA_WIDTH+1 (the extra bit is valid).
- The top level holds the FSM, flush_cnt and the generate loop over lanes.

## Test plan
- Single vector {1,2,3,4} (lane0..3) with last=1, accepted at cycle t:
  - lane0=1 at t+1, lane1=2 at t+2, lane2=3 at t+3, lane3=4 at t+4;
  - all other lane cycles are 0;
  - tile_done_o is high at t+8 only.
- Four back-to-back vectors, vector k = {k,k,k,k} for k=1..4, last on k=4:
  - lane r shows 1,2,3,4 in cycles t+1+r … t+4+r;
  - acc_en_o stays continuously high until tile_done_o.
- Bubble: vectors 5 and 6 with in_valid_i low for one cycle between them:
  - each lane shows 5, then 0 with row_valid_o[r]=0, then 6;
  - spacing is identical on all lanes.
- Backpressure: hold in_valid_i high during FLUSH:
  - in_ready_o=0 for exactly 7 cycles;
  - the held vector is accepted in the tile_done_o cycle and starts the next tile.
- Reset mid-tile: assert rst two cycles after the first handshake:
  - the next cycle shows data_a_o=0, row_valid_o=0, acc_en_o=0;
  - tile_done_o never pulses;
  - in_ready_o=1 one cycle after rst deasserts.
- Signed extremes: vector {-128,127,-1,0} passes bit-exact on each lane at its skewed cycle.
